// File: rtl/arbitro_rr_pkg.sv
// Shared constants for the round-robin VC-to-destination arbiter.
// State encodings stay plain logic constants so older debug tooling can decode them.
package arbitro_rr_pkg;

    localparam int NUM_Q = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARB   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    // The destination index is the top two bits of each word.
    function automatic int dst_msb(input int bitnumber);
        return bitnumber - 1;
    endfunction

    function automatic int dst_lsb(input int bitnumber);
        return bitnumber - 2;
    endfunction

    function automatic logic [NUM_Q-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_Q-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/arbitro_rr_pick4.sv
// Combinational round-robin picker: first set bit of eligible,
// scanning from ptr upward modulo 4.
module rr_pick4
    import arbitro_rr_pkg::*;
(
    input  logic [NUM_Q-1:0] eligible,
    input  logic [1:0]       ptr,
    output logic [NUM_Q-1:0] grant,
    output logic             valid
);

    logic [1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            idx = ptr + 2'(k);
            if (!valid && eligible[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter popping four source FIFOs and routing each returned
// word to one of four destination FIFOs by its two MSBs.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int BITNUMBER = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_Q-1:0]           src_empty,
    input  logic [NUM_Q-1:0]           src_valid,
    input  logic [NUM_Q*BITNUMBER-1:0] src_data,
    input  logic [NUM_Q-1:0]           dst_pause,
    input  logic [NUM_Q-1:0]           dst_full,
    output logic [NUM_Q-1:0]           pop,
    output logic [NUM_Q-1:0]           push,
    output logic [BITNUMBER-1:0]       data_out,
    output logic [1:0]                 state,
    output logic [2:0]                 in_flight,
    output logic                       drop_error,
    output logic [7:0]                 word_count
);

    localparam int DMSB = dst_msb(BITNUMBER);
    localparam int DLSB = dst_lsb(BITNUMBER);

    logic [1:0]           rr_ptr;
    logic [1:0]           next_state;
    logic [NUM_Q-1:0]     eligible;
    logic [NUM_Q-1:0]     grant;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic                 issue;

    logic                 any_valid;
    logic                 multi_valid;
    logic [1:0]           sel;
    logic [BITNUMBER-1:0] word;
    logic [1:0]           dst;
    logic                 blocked;

    // A source popped this cycle is skipped next cycle: its empty flag lags by one.
    assign eligible = ~src_empty & ~pop;

    rr_pick4 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant),
        .valid    (grant_valid)
    );

    always_comb begin
        if (|dst_pause)
            next_state = PAUSE;
        else if (|eligible)
            next_state = ARB;
        else
            next_state = IDLE;
    end

    assign issue = (next_state == ARB) && grant_valid;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_Q; k++)
            if (grant[k]) grant_idx = 2'(k);
    end

    // Return path: lowest set valid wins; more than one set is flagged as an error.
    always_comb begin
        sel = '0;
        for (int k = NUM_Q - 1; k >= 0; k--)
            if (src_valid[k]) sel = 2'(k);
    end

    assign any_valid   = |src_valid;
    assign multi_valid = (src_valid & (src_valid - 4'd1)) != '0;
    assign word        = src_data[int'(sel)*BITNUMBER +: BITNUMBER];
    assign dst         = word[DMSB:DLSB];
    assign blocked     = dst_full[dst];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            pop        <= '0;
            push       <= '0;
            data_out   <= '0;
            in_flight  <= '0;
            drop_error <= 1'b0;
            word_count <= '0;
        end else begin
            state     <= next_state;
            pop       <= issue ? grant : '0;
            in_flight <= in_flight + 3'(issue) - 3'(any_valid);
            push      <= '0;
            if (issue)
                rr_ptr <= grant_idx + 2'd1;
            if (any_valid) begin
                if (blocked) begin
                    drop_error <= 1'b1;
                end else begin
                    push       <= onehot4(dst);
                    data_out   <= word;
                    word_count <= word_count + 8'd1;
                end
                if (multi_valid)
                    drop_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: a responder returns popped words, a
// scoreboard queue holds expected pushes, and a monitor checks them.
module tb_arbitro_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_empty;
    logic [3:0]  src_valid;
    logic [23:0] src_data;
    logic [3:0]  dst_pause;
    logic [3:0]  dst_full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [5:0]  data_out;
    logic [1:0]  state;
    logic [2:0]  in_flight;
    logic        drop_error;
    logic [7:0]  word_count;

    logic [5:0]  sw [4];
    logic        resp_en;
    logic [3:0]  force_valid;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_count;

    typedef struct {
        logic [3:0] push;
        logic [5:0] data;
        logic [7:0] count;
        int         due;
    } exp_t;
    exp_t q[$];

    assign src_data = {sw[3], sw[2], sw[1], sw[0]};

    arbitro_rr #(.BITNUMBER(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_empty  (src_empty),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .dst_pause  (dst_pause),
        .dst_full   (dst_full),
        .pop        (pop),
        .push       (push),
        .data_out   (data_out),
        .state      (state),
        .in_flight  (in_flight),
        .drop_error (drop_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Source model: valid follows a pop by one cycle (or a forced vector).
    task automatic responder_loop();
        logic [3:0] v;
        logic [5:0] w;
        int         idx;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                src_valid = '0;
                exp_count = '0;
                q.delete();
            end else begin
                v = resp_en ? pop : force_valid;
                src_valid = v;
                if (v != '0) begin
                    idx = 0;
                    for (int k = 3; k >= 0; k--)
                        if (v[k]) idx = k;
                    w = sw[idx];
                    if (!dst_full[w[5:4]]) begin
                        exp_count = exp_count + 8'd1;
                        q.push_back('{push: 4'b0001 << w[5:4], data: w, count: exp_count, due: cyc + 1});
                    end
                end
            end
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("sb_push", 32'(push), 32'(e.push));
                check("sb_data_out", 32'(data_out), 32'(e.data));
                check("sb_word_count", 32'(word_count), 32'(e.count));
            end else if (push != '0) begin
                check("unexpected_push", 32'(push), 32'd0);
            end
        end
    endtask

    initial begin
        logic [3:0] fair_seq [4];
        logic [3:0] single_seq [5];
        fair_seq   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        single_seq = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};

        reset       = 1'b1;
        src_empty   = 4'b0000;
        src_valid   = '0;
        dst_pause   = '0;
        dst_full    = '0;
        resp_en     = 1'b1;
        force_valid = '0;
        exp_count   = '0;
        sw[0] = 6'b00_0001;
        sw[1] = 6'b01_0010;
        sw[2] = 6'b10_0011;
        sw[3] = 6'b11_0100;

        fork
            responder_loop();
            monitor_loop();
        join_none

        // Reset held two cycles with every source non-empty
        tick(2);
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_push", 32'(push), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_in_flight", 32'(in_flight), 32'd0);
        check("rst_drop_error", 32'(drop_error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;

        // Fairness across four busy sources
        tick(1);
        check("first_pop", 32'(pop), 32'b0001);
        check("arb_state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("fair_pop", 32'(pop), 32'(fair_seq[i]));
        end
        check("fair_in_flight", 32'(in_flight), 32'd1);
        src_empty = 4'hF;
        tick(3);
        check("fair_drained", 32'(in_flight), 32'd0);
        check("fair_idle", 32'(state), 32'd0);
        check("fair_count", 32'(word_count), 32'd5);

        // Mid-run reset clears the counter
        reset = 1'b1;
        tick(1);
        check("rst2_word_count", 32'(word_count), 32'd0);
        check("rst2_state", 32'(state), 32'd0);
        reset = 1'b0;

        // Routing: source 2 returns a word for destination 2
        resp_en   = 1'b0;
        sw[2]     = 6'b10_0101;
        src_empty = 4'b1011;
        tick(1);
        check("route_pop", 32'(pop), 32'b0100);
        src_empty   = 4'hF;
        force_valid = 4'b0100;
        tick(1);
        force_valid = '0;
        tick(1);
        check("route_push", 32'(push), 32'b0100);
        check("route_data", 32'(data_out), 32'b100101);
        check("route_count", 32'(word_count), 32'd1);
        tick(1);
        check("route_push_idle", 32'(push), 32'd0);
        check("route_data_hold", 32'(data_out), 32'b100101);
        check("route_in_flight", 32'(in_flight), 32'd0);

        // Pause with two words in flight
        src_empty = 4'b1100;
        tick(1);
        check("pause_pop_a", 32'(pop), 32'b0001);
        tick(1);
        check("pause_pop_b", 32'(pop), 32'b0010);
        check("pause_in_flight", 32'(in_flight), 32'd2);
        dst_pause = 4'b0010;
        tick(1);
        check("pause_pop_off", 32'(pop), 32'd0);
        check("pause_state", 32'(state), 32'd2);
        force_valid = 4'b0001;
        tick(1);
        force_valid = 4'b0010;
        tick(1);
        force_valid = '0;
        tick(1);
        check("pause_delivered", 32'(in_flight), 32'd0);
        check("pause_held", 32'(state), 32'd2);
        check("pause_no_pop", 32'(pop), 32'd0);
        check("pause_count", 32'(word_count), 32'd3);
        dst_pause = '0;
        tick(1);
        check("resume_pop", 32'(pop), 32'b0001);
        check("resume_state", 32'(state), 32'd1);
        src_empty   = 4'hF;
        force_valid = 4'b0001;
        tick(1);
        force_valid = '0;
        tick(1);
        check("resume_in_flight", 32'(in_flight), 32'd0);

        // Full destination drops the word
        resp_en   = 1'b1;
        dst_full  = 4'b1000;
        src_empty = 4'b0111;
        tick(1);
        check("drop_pop", 32'(pop), 32'b1000);
        src_empty = 4'hF;
        tick(1);
        check("drop_push", 32'(push), 32'd0);
        check("drop_error_set", 32'(drop_error), 32'd1);
        check("drop_count", 32'(word_count), 32'd4);
        dst_full = '0;
        tick(2);
        check("drop_error_sticky", 32'(drop_error), 32'd1);
        check("drop_in_flight", 32'(in_flight), 32'd0);

        // Single source alternates pop cycles
        src_empty = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("single_pop", 32'(pop), 32'(single_seq[i]));
        end
        src_empty = 4'hF;
        tick(3);
        check("single_in_flight", 32'(in_flight), 32'd0);
        check("single_state", 32'(state), 32'd0);
        check("single_count", 32'(word_count), 32'd7);
        check("queue_drained", 32'(q.size()), 32'd0);

        // Reset clears the sticky error
        reset = 1'b1;
        tick(1);
        check("rst3_drop_error", 32'(drop_error), 32'd0);
        check("rst3_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
